memory_arbiter: RTL and testbench

Two-port arbiter that lets the instruction fetch path (port 0) and the data load/store path (port 1) share one downstream memory port: the instruction cache / BIOS ROM request–response channel. Requests are granted one per cycle and forwarded downstream. An internal order FIFO records which port owns each outstanding request, so that in-order downstream responses are routed back to the correct requester. The block sits between the CPU pipeline ports and the memory-side channel, and adds no latency on either path.

---
 rtl/memory_arbiter.sv | 138 +++++++++++++
 tb/tb_memory_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-port request/response arbiter sharing one downstream memory channel, with an
// order FIFO for in-order response routing. Define ROUND_ROBIN_EN for round-robin contention.
module memory_arbiter #(
  parameter int ADDR_WIDTH      = 30,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr_i,
  input  logic                  m0_req_valid_i,
  output logic                  m0_req_ready_o,
  output logic [ADDR_WIDTH-1:0] m0_resp_addr_o,
  output logic [DATA_WIDTH-1:0] m0_resp_data_o,
  output logic                  m0_resp_valid_o,
  input  logic                  m0_resp_ready_i,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr_i,
  input  logic                  m1_req_valid_i,
  output logic                  m1_req_ready_o,
  output logic [ADDR_WIDTH-1:0] m1_resp_addr_o,
  output logic [DATA_WIDTH-1:0] m1_resp_data_o,
  output logic                  m1_resp_valid_o,
  input  logic                  m1_resp_ready_i,
  output logic [ADDR_WIDTH-1:0] s_req_addr_o,
  output logic                  s_req_valid_o,
  input  logic                  s_req_ready_i,
  input  logic [ADDR_WIDTH-1:0] s_resp_addr_i,
  input  logic [DATA_WIDTH-1:0] s_resp_data_i,
  input  logic                  s_resp_valid_i,
  output logic                  s_resp_ready_o
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic             lock_vld;
  logic             lock_port;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             order_mem [MAX_OUTSTANDING];

  logic fifo_full;
  logic fifo_empty;
  logic both_req;
  logic fav_port;
  logic grant_port;
  logic grant_req;
  logic req_accept;
  logic head_port;
  logic resp_route;
  logic resp_accept;

  assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign both_req   = m0_req_valid_i && m1_req_valid_i;

`ifdef ROUND_ROBIN_EN
  logic rr_ptr;

  // Favoured port flips only when an accept resolved real contention.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rr_ptr <= 1'b0;
    end else if (req_accept && both_req) begin
      rr_ptr <= ~grant_port;
    end
  end

  assign fav_port = rr_ptr;
`else
  assign fav_port = 1'b1;
`endif

  always_comb begin
    grant_port = 1'b0;
    if (lock_vld) begin
      grant_port = lock_port;
    end else if (both_req) begin
      grant_port = fav_port;
    end else begin
      grant_port = m1_req_valid_i;
    end
    grant_req = grant_port ? m1_req_valid_i : m0_req_valid_i;
  end

  // Request path: purely combinational mux of the granted port.
  assign s_req_valid_o  = reset_ni && grant_req && !fifo_full;
  assign s_req_addr_o   = !s_req_valid_o ? '0 :
                          (grant_port ? m1_req_addr_i : m0_req_addr_i);
  assign req_accept     = s_req_valid_o && s_req_ready_i;
  assign m0_req_ready_o = req_accept && !grant_port;
  assign m1_req_ready_o = req_accept && grant_port;

  // Response path: the oldest outstanding owner steers the downstream response.
  assign head_port       = order_mem[rd_ptr];
  assign resp_route      = reset_ni && !fifo_empty;
  assign s_resp_ready_o  = resp_route && (head_port ? m1_resp_ready_i : m0_resp_ready_i);
  assign m0_resp_valid_o = resp_route && s_resp_valid_i && !head_port;
  assign m1_resp_valid_o = resp_route && s_resp_valid_i && head_port;
  assign m0_resp_addr_o  = m0_resp_valid_o ? s_resp_addr_i : '0;
  assign m0_resp_data_o  = m0_resp_valid_o ? s_resp_data_i : '0;
  assign m1_resp_addr_o  = m1_resp_valid_o ? s_resp_addr_i : '0;
  assign m1_resp_data_o  = m1_resp_valid_o ? s_resp_data_i : '0;
  assign resp_accept     = s_resp_valid_i && s_resp_ready_o;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lock_vld  <= 1'b0;
      lock_port <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      // A stalled forward holds the grant; a lock never coexists with a push.
      lock_vld <= s_req_valid_o && !s_req_ready_i;
      if (s_req_valid_o && !s_req_ready_i) begin
        lock_port <= grant_port;
      end
      if (req_accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (resp_accept) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({req_accept, resp_accept})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (req_accept) begin
      order_mem[wr_ptr] <= grant_port;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: combinational vector table plus scoreboarded
// multi-cycle sequences (contention, full, routing, lock, reset mid-traffic).
module tb_memory_arbiter;
  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [29:0] m0_req_addr_i, m1_req_addr_i, s_resp_addr_i;
  logic        m0_req_valid_i, m1_req_valid_i;
  logic        m0_req_ready_o, m1_req_ready_o;
  logic [29:0] m0_resp_addr_o, m1_resp_addr_o, s_req_addr_o;
  logic [31:0] m0_resp_data_o, m1_resp_data_o, s_resp_data_i;
  logic        m0_resp_valid_o, m1_resp_valid_o;
  logic        m0_resp_ready_i, m1_resp_ready_i;
  logic        s_req_valid_o, s_req_ready_i;
  logic        s_resp_valid_i, s_resp_ready_o;

  memory_arbiter #(.ADDR_WIDTH(30), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .m0_req_addr_i(m0_req_addr_i), .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o),
    .m0_resp_addr_o(m0_resp_addr_o), .m0_resp_data_o(m0_resp_data_o),
    .m0_resp_valid_o(m0_resp_valid_o), .m0_resp_ready_i(m0_resp_ready_i),
    .m1_req_addr_i(m1_req_addr_i), .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o),
    .m1_resp_addr_o(m1_resp_addr_o), .m1_resp_data_o(m1_resp_data_o),
    .m1_resp_valid_o(m1_resp_valid_o), .m1_resp_ready_i(m1_resp_ready_i),
    .s_req_addr_o(s_req_addr_o), .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i),
    .s_resp_addr_i(s_resp_addr_i), .s_resp_data_i(s_resp_data_i),
    .s_resp_valid_i(s_resp_valid_i), .s_resp_ready_o(s_resp_ready_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic v0, v1, sr, srv;
    logic ev, er0, er1, esrr, erv0, erv1;
    logic [29:0] eaddr;
  } vec_t;

  typedef struct {
    logic        port;
    logic [29:0] addr;
  } sb_t;

  localparam logic [29:0] A0 = 30'h100;
  localparam logic [29:0] A1 = 30'h200;

  int   total = 0;
  int   bad = 0;
  vec_t vecs[7];
  sb_t  sb[$];

  function automatic vec_t mk(logic v0, logic v1, logic sr, logic srv, logic ev, logic er0,
                              logic er1, logic esrr, logic erv0, logic erv1, logic [29:0] ea);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.sr = sr; v.srv = srv;
    v.ev = ev; v.er0 = er0; v.er1 = er1; v.esrr = esrr; v.erv0 = erv0; v.erv1 = erv1;
    v.eaddr = ea;
    return v;
  endfunction

  function automatic logic [31:0] dataf(input logic [29:0] a);
    return {a, 2'b11} ^ 32'hC3A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req_valid_i = 1'b0; m0_req_addr_i = '0;
    m1_req_valid_i = 1'b0; m1_req_addr_i = '0;
    s_req_ready_i  = 1'b0;
    s_resp_valid_i = 1'b0; s_resp_addr_i = '0; s_resp_data_i = '0;
    m0_resp_ready_i = 1'b1; m1_resp_ready_i = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Combinational check from the idle state; inputs return to idle before the edge.
  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    m0_req_valid_i = v.v0; m0_req_addr_i = A0;
    m1_req_valid_i = v.v1; m1_req_addr_i = A1;
    s_req_ready_i  = v.sr;
    s_resp_valid_i = v.srv; s_resp_addr_i = 30'h3FF; s_resp_data_i = 32'hDEAD_BEEF;
    #1;
    chk($sformatf("vec%0d_sreqv", i), 32'(s_req_valid_o), 32'(v.ev));
    chk($sformatf("vec%0d_addr", i), 32'(s_req_addr_o), 32'(v.eaddr));
    chk($sformatf("vec%0d_rdy0", i), 32'(m0_req_ready_o), 32'(v.er0));
    chk($sformatf("vec%0d_rdy1", i), 32'(m1_req_ready_o), 32'(v.er1));
    chk($sformatf("vec%0d_srespr", i), 32'(s_resp_ready_o), 32'(v.esrr));
    chk($sformatf("vec%0d_rv", i), 32'({m1_resp_valid_o, m0_resp_valid_o}),
        32'({v.erv1, v.erv0}));
    idle_inputs();
    cyc();
  endtask

  task automatic req_cycle(input logic v0, input logic [29:0] a0, input logic v1,
                           input logic [29:0] a1, input logic sr, input logic ev,
                           input logic gp, input string tag);
    logic acc;
    m0_req_valid_i = v0; m0_req_addr_i = a0;
    m1_req_valid_i = v1; m1_req_addr_i = a1;
    s_req_ready_i  = sr;
    #1;
    acc = ev && sr;
    chk({tag, "_sreqv"}, 32'(s_req_valid_o), 32'(ev));
    chk({tag, "_addr"}, 32'(s_req_addr_o), ev ? 32'(gp ? a1 : a0) : 32'h0);
    chk({tag, "_rdy"}, 32'({m1_req_ready_o, m0_req_ready_o}),
        32'({acc && gp, acc && !gp}));
    if (acc) sb.push_back('{port: gp, addr: (gp ? a1 : a0)});
    cyc();
  endtask

  task automatic resp_cycle(input logic rdy0, input logic rdy1, input logic exp_sreqv,
                            input string tag);
    sb_t  e;
    logic esrr;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_sb got=empty want=entry", tag);
      return;
    end
    e = sb[0];
    s_resp_valid_i = 1'b1; s_resp_addr_i = e.addr; s_resp_data_i = dataf(e.addr);
    m0_resp_ready_i = rdy0; m1_resp_ready_i = rdy1;
    #1;
    esrr = e.port ? rdy1 : rdy0;
    chk({tag, "_srespr"}, 32'(s_resp_ready_o), 32'(esrr));
    chk({tag, "_rv"}, 32'({m1_resp_valid_o, m0_resp_valid_o}), 32'({e.port, !e.port}));
    chk({tag, "_raddr"}, 32'(e.port ? m1_resp_addr_o : m0_resp_addr_o), 32'(e.addr));
    chk({tag, "_rdata"}, e.port ? m1_resp_data_o : m0_resp_data_o, dataf(e.addr));
    chk({tag, "_sreqv"}, 32'(s_req_valid_o), 32'(exp_sreqv));
    if (esrr) void'(sb.pop_front());
    cyc();
    s_resp_valid_i = 1'b0;
    m0_resp_ready_i = 1'b1; m1_resp_ready_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fav;
    logic gp;
`ifdef ROUND_ROBIN_EN
    vecs[3] = mk(1, 1, 1, 0, 1, 1, 0, 0, 0, 0, A0);
`else
    vecs[3] = mk(1, 1, 1, 0, 1, 0, 1, 0, 0, 0, A1);
`endif
    vecs[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30'h0);
    vecs[1] = mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, A0);
    vecs[2] = mk(0, 1, 1, 0, 1, 0, 1, 0, 0, 0, A1);
    vecs[4] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, A0);
    vecs[5] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 30'h0);
    vecs[6] = mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, A1);

    // Reset state with active inputs: every valid/ready output must be low.
    idle_inputs();
    reset_ni = 1'b0;
    m0_req_valid_i = 1'b1; m0_req_addr_i = A0; s_req_ready_i = 1'b1;
    s_resp_valid_i = 1'b1; s_resp_addr_i = 30'h55; s_resp_data_i = 32'h1234;
    #12;
    chk("rst_sreqv", 32'(s_req_valid_o), 32'h0);
    chk("rst_saddr", 32'(s_req_addr_o), 32'h0);
    chk("rst_rdy", 32'({m1_req_ready_o, m0_req_ready_o}), 32'h0);
    chk("rst_srespr", 32'(s_resp_ready_o), 32'h0);
    chk("rst_rv", 32'({m1_resp_valid_o, m0_resp_valid_o}), 32'h0);
    chk("rst_rdata", m0_resp_data_o | m1_resp_data_o, 32'h0);
    idle_inputs();
    #2 reset_ni = 1'b1;
    cyc();

    for (int i = 0; i < 7; i++) apply_vec(i);

    // Contention with sustained ready: fills the FIFO exactly.
`ifdef ROUND_ROBIN_EN
    fav = 1'b0;
`else
    fav = 1'b1;
`endif
    for (int i = 0; i < 4; i++) begin
      gp = fav;
`ifdef ROUND_ROBIN_EN
      fav = ~gp;
`endif
      req_cycle(1, A0 + 30'(i), 1, A1 + 30'(i), 1, 1, gp, $sformatf("cont%0d", i));
    end

    // Full: forwarding blocked, a pop frees a slot only for the next cycle.
    req_cycle(1, A0, 1, A1, 1, 0, 0, "full_block");
    resp_cycle(1, 1, 0, "full_pop");
    req_cycle(1, A0 + 30'h8, 1, A1 + 30'h8, 1, 1, fav, "full_after");
    idle_inputs();
    for (int i = 0; i < 4; i++) resp_cycle(1, 1, 0, $sformatf("drain%0d", i));

    // Routing with a stalled port-1 consumer.
    req_cycle(1, 30'h40, 0, 30'h0, 1, 1, 0, "rt_p0a");
    req_cycle(0, 30'h0, 1, 30'h44, 1, 1, 1, "rt_p1");
    req_cycle(1, 30'h48, 0, 30'h0, 1, 1, 0, "rt_p0c");
    idle_inputs();
    resp_cycle(1, 1, 0, "rt_A");
    resp_cycle(1, 0, 0, "rt_stall0");
    resp_cycle(1, 0, 0, "rt_stall1");
    resp_cycle(1, 1, 0, "rt_B");
    resp_cycle(1, 1, 0, "rt_C");

    // Lock: port 0 held through three stalled cycles while port 1 waits.
    req_cycle(1, 30'h20, 0, 30'h0, 0, 1, 0, "lock1");
    req_cycle(1, 30'h20, 1, 30'h30, 0, 1, 0, "lock2");
    req_cycle(1, 30'h20, 1, 30'h30, 0, 1, 0, "lock3");
    req_cycle(1, 30'h20, 1, 30'h30, 1, 1, 0, "lock_acc");
    req_cycle(0, 30'h0, 1, 30'h30, 1, 1, 1, "lock_next");
    idle_inputs();
    resp_cycle(1, 1, 0, "lock_r0");
    resp_cycle(1, 1, 0, "lock_r1");

    // Reset with three outstanding requests and live traffic.
    req_cycle(1, 30'h50, 0, 30'h0, 1, 1, 0, "mr0");
    req_cycle(1, 30'h54, 0, 30'h0, 1, 1, 0, "mr1");
    req_cycle(1, 30'h58, 0, 30'h0, 1, 1, 0, "mr2");
    m0_req_valid_i = 1'b1; m0_req_addr_i = 30'h60; s_req_ready_i = 1'b1;
    s_resp_valid_i = 1'b1; s_resp_addr_i = 30'h50; s_resp_data_i = dataf(30'h50);
    reset_ni = 1'b0;
    #1;
    chk("mrst_sreqv", 32'(s_req_valid_o), 32'h0);
    chk("mrst_rdy", 32'({m1_req_ready_o, m0_req_ready_o}), 32'h0);
    chk("mrst_srespr", 32'(s_resp_ready_o), 32'h0);
    chk("mrst_rv", 32'({m1_resp_valid_o, m0_resp_valid_o}), 32'h0);
    #3 reset_ni = 1'b1;
    sb.delete();
    idle_inputs();
    cyc();
    req_cycle(1, 30'h10, 0, 30'h0, 1, 1, 0, "post_rst");
    idle_inputs();
    resp_cycle(1, 1, 0, "post_rst_resp");

    // Stray response once the FIFO has drained back to empty.
    apply_vec(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
